// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two requesters.
// Port 0 has fixed priority. A starvation counter forces a grant to port 1
// after it has waited STARVE_MAX consecutive cycles.
// Optional build macro MEM_ARB_RR_EN: switches to round-robin arbitration.
// In that build the starvation counter is not built.
// Handshake: a request is accepted in a cycle where pn_valid && pn_ready.
// pn_ready is combinational. The requester keeps addr/wdata/wmask stable
// while valid is high and ready is low. Dropping valid withdraws the request.
// A read accepted in cycle t returns on pn_rvalid in t+1, with
// pn_rdata = mem_rdata.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        p0_valid,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wmask,
    output logic        p0_ready,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    input  logic        p1_valid,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wmask,
    output logic        p1_ready,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata
);

    // grant0/grant1 already include the port's valid, so a grant is an accept
    logic       grant0;
    logic       grant1;
    logic [3:0] sel_wmask;
    logic       rd_accept;
    logic       pend_valid;
    logic       pend_tag;

`ifdef MEM_ARB_RR_EN
    // rr_ptr names the port that wins when both ports request
    logic rr_ptr;

    // Round-robin choice. A lone requester always wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (resetn) begin
            if (p0_valid && p1_valid) begin
                grant0 = ~rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = p0_valid;
                grant1 = p1_valid;
            end
        end
    end

    // Pointer moves to the port after the one just granted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= 1'b0;
        end else if (grant0) begin
            rr_ptr <= 1'b1;
        end else if (grant1) begin
            rr_ptr <= 1'b0;
        end
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt >= STARVE_LIM);

    // Fixed priority for port 0, overridden once port 1 has starved
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (resetn) begin
            grant1 = p1_valid & (~p0_valid | starved);
            grant0 = p0_valid & ~grant1;
        end
    end

    // Count cycles port 1 waits; the count saturates and clears on accept or on withdraw
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= 8'd0;
        end else if (!p1_valid || grant1) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`endif

    assign p0_ready = grant0;
    assign p1_ready = grant1;

    // Memory-side mux. Without a grant, address and data follow port 0 and no access is strobed.
    always_comb begin
        sel_wmask = 4'b0000;
        if (grant0) begin
            sel_wmask = p0_wmask;
        end else if (grant1) begin
            sel_wmask = p1_wmask;
        end
        mem_addr  = grant1 ? p1_addr  : p0_addr;
        mem_wdata = grant1 ? p1_wdata : p0_wdata;
        mem_wmask = sel_wmask;
        rd_accept = (grant0 | grant1) & (sel_wmask == 4'b0000);
        mem_rstrb = rd_accept;
    end

    // Remember which port owns the read whose data returns next cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_valid <= 1'b0;
            pend_tag   <= 1'b0;
        end else begin
            pend_valid <= rd_accept;
            pend_tag   <= grant1;
        end
    end

    assign p0_rvalid = pend_valid & ~pend_tag;
    assign p1_rvalid = pend_valid & pend_tag;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter.
// The bench uses a 64-word memory with 1-cycle read latency. It also keeps
// a reference model: a reference memory, the arbitration rules, and a queue
// of expected read data.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int STARVE_MAX = 8;

    logic        clk;
    logic        resetn;
    logic        p0_valid, p1_valid;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [3:0]  p0_wmask, p1_wmask;
    logic        p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .resetn(resetn),
        .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory ----------------
    logic [31:0] mem      [0:63];
    logic [31:0] init_img [0:63];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_img[i];
        end else begin
            if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] ref_mem [0:63];
    logic [31:0] exp_q[$];
    int          exp_tag;   // port owning the read due this cycle, -1 none
    int          p1_wait;   // consecutive cycles port 1 has been left waiting
    int          rr_next;   // port favoured when both request
    int          last_g;    // port accepted in the most recent checked cycle
    int          n_tests, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_tag = -1;
        p1_wait = 0;
        rr_next = 0;
        last_g  = -1;
    endtask

    // Called at the negative edge: predict this cycle's behaviour, compare, then advance the model
    task automatic model_check();
        int          g;
        logic [3:0]  m;
        logic [31:0] a, d;
        g = -1;
        if (p0_valid && p1_valid) begin
`ifdef MEM_ARB_RR_EN
            g = rr_next;
`else
            g = (p1_wait >= STARVE_MAX) ? 1 : 0;
`endif
        end else if (p0_valid) begin
            g = 0;
        end else if (p1_valid) begin
            g = 1;
        end
        m = (g == 0) ? p0_wmask : (g == 1) ? p1_wmask : 4'b0000;
        a = (g == 1) ? p1_addr  : p0_addr;
        d = (g == 1) ? p1_wdata : p0_wdata;

        chk("p0_ready",  32'(p0_ready),  32'(g == 0));
        chk("p1_ready",  32'(p1_ready),  32'(g == 1));
        chk("mem_wmask", 32'(mem_wmask), 32'(m));
        chk("mem_rstrb", 32'(mem_rstrb), 32'(g >= 0 && m == 4'b0000));
        chk("mem_addr",  mem_addr, a);
        if (g >= 0) chk("mem_wdata", mem_wdata, d);
        chk("p0_rvalid", 32'(p0_rvalid), 32'(exp_tag == 0));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(exp_tag == 1));
        chk("p0_rdata_pass", p0_rdata, mem_rdata);
        chk("p1_rdata_pass", p1_rdata, mem_rdata);
        if (exp_tag >= 0 && exp_q.size() > 0)
            chk("rdata", (exp_tag == 0) ? p0_rdata : p1_rdata, exp_q.pop_front());

        exp_tag = -1;
        if (g >= 0) begin
            if (m == 4'b0000) begin
                exp_q.push_back(ref_mem[a[7:2]]);
                exp_tag = g;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
            end
            rr_next = 1 - g;
        end
        if (!p1_valid || g == 1) p1_wait = 0;
        else p1_wait++;
        last_g = g;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        if (p == 0) begin
            p0_valid = v; p0_addr = a; p0_wdata = d; p0_wmask = m;
        end else begin
            p1_valid = v; p1_addr = a; p1_wdata = d; p1_wmask = m;
        end
    endtask

    task automatic rand_req(input int p);
        logic [31:0] a;
        logic [3:0]  m;
        a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        m = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        set_req(p, 1'($urandom_range(0, 3) != 0), a, $urandom, m);
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic exp1;
        logic [31:0] wd;
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        preload = 1'b1;
        set_req(0, 1'b1, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h4, 32'h1234_5678, 4'hF);
        for (int i = 0; i < 64; i++) init_img[i] = $urandom;
        init_img[4] = 32'hDEAD_BEEF;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_img[i];
        model_reset();

        // outputs held inactive during reset even with requests present
        next();
        preload = 1'b0;
        chk("rst_p0_ready",  32'(p0_ready),  32'd0);
        chk("rst_p1_ready",  32'(p1_ready),  32'd0);
        chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_mem_rstrb", 32'(mem_rstrb), 32'd0);
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        #2 resetn = 1'b1;
        at_neg();
        next();

        // p0 read of 0x10
        set_req(0, 1'b1, 32'h10, 32'h0, 4'b0000);
        at_neg();
        chk("r030_p0_ready", 32'(p0_ready), 32'd1);
        chk("r030_rstrb",    32'(mem_rstrb), 32'd1);
        next();
        set_req(0, 1'b0, 32'h0, 32'h0, 4'b0000);
        at_neg();
        chk("r030_rvalid",    32'(p0_rvalid), 32'd1);
        chk("r030_rdata",     p0_rdata, 32'hDEAD_BEEF);
        chk("r030_p1_rvalid", 32'(p1_rvalid), 32'd0);
        next();

        // p0 byte-2 write to 0x20, then p1 reads it back
        set_req(0, 1'b1, 32'h20, 32'h00AB_0000, 4'b0100);
        at_neg();
        next();
        set_req(0, 1'b0, 32'h0, 32'h0, 4'b0000);
        set_req(1, 1'b1, 32'h20, 32'h0, 4'b0000);
        at_neg();
        next();
        set_req(1, 1'b0, 32'h0, 32'h0, 4'b0000);
        at_neg();
        chk("r031_byte2",  32'(p1_rdata[23:16]), 32'h0000_00AB);
        chk("r031_others", 32'({p1_rdata[31:24], p1_rdata[15:0]}),
            32'({init_img[8][31:24], init_img[8][15:0]}));
        next();

        // p0 read then p1 write: rvalid of the read overlaps the write accept
        set_req(0, 1'b1, 32'h30, 32'h0, 4'b0000);
        at_neg();
        next();
        wd = $urandom;
        set_req(0, 1'b0, 32'h0, 32'h0, 4'b0000);
        set_req(1, 1'b1, 32'h34, wd, 4'b1011);
        at_neg();
        chk("r035_p0_rvalid", 32'(p0_rvalid), 32'd1);
        chk("r035_p1_ready",  32'(p1_ready),  32'd1);
        chk("r035_wmask",     32'(mem_wmask), 32'h0000_000B);
        next();
        set_req(1, 1'b0, 32'h0, 32'h0, 4'b0000);
        at_neg();
        next();

        // reset pulse while a p1 read is outstanding
        set_req(1, 1'b1, 32'h14, 32'h0, 4'b0000);
        at_neg();
        next();
        set_req(1, 1'b0, 32'h0, 32'h0, 4'b0000);
        set_req(0, 1'b1, 32'h18, 32'h0, 4'b0000);
        resetn = 1'b0;
        #1;
        chk("r034_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("r034_p0_ready",  32'(p0_ready),  32'd0);
        chk("r034_rstrb",     32'(mem_rstrb), 32'd0);
        chk("r034_wmask",     32'(mem_wmask), 32'd0);
        model_reset();
        set_req(0, 1'b0, 32'h0, 32'h0, 4'b0000);
        #1 resetn = 1'b1;
        at_neg();
        chk("r034_after_rel", 32'(p1_rvalid), 32'd0);
        next();
        at_neg();
        chk("r034_after_rel2", 32'(p1_rvalid), 32'd0);
        next();

        // both ports requesting continuously
        set_req(0, 1'b1, 32'h40, 32'h0, 4'b0000);
        set_req(1, 1'b1, 32'h44, 32'h0, 4'b0000);
        for (int i = 1; i <= 18; i++) begin
            at_neg();
`ifdef MEM_ARB_RR_EN
            exp1 = (i % 2 == 0);
`else
            exp1 = (i == 9 || i == 18);
`endif
            chk("r032_p1_grant", 32'(p1_ready), 32'(exp1));
            chk("r032_p0_grant", 32'(p0_ready), 32'(!exp1));
            next();
            if (last_g == 0) set_req(0, 1'b1, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, 32'h0, 4'b0000);
            else             set_req(1, 1'b1, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, 32'h0, 4'b0000);
        end

        // random traffic obeying the hold-or-withdraw rule
        for (int c = 0; c < 400; c++) begin
            at_neg();
            next();
            if (last_g == 0 || !p0_valid) rand_req(0);
            else if ($urandom_range(0, 9) == 0) p0_valid = 1'b0;
            if (last_g == 1 || !p1_valid) rand_req(1);
            else if ($urandom_range(0, 9) == 0) p1_valid = 1'b0;
        end

        // drain
        set_req(0, 1'b0, 32'h0, 32'h0, 4'b0000);
        set_req(1, 1'b0, 32'h0, 32'h0, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            at_neg();
            next();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
